// File: rtl/mars_crew_decoder_if.sv
// Candidate code handshake between the trait classifier and the crew decoder.
// The classifier drives a class code with a valid flag.
// The decoder answers with ready whenever it is collecting a crew.
interface mars_crew_decoder_if;
    logic       code_valid;
    logic [2:0] code;
    logic       code_ready;

    modport master (output code_valid, output code, input code_ready);
    modport slave  (input code_valid, input code, output code_ready);
endinterface

// File: rtl/mars_crew_decoder.sv
// Mars crew decoder.
// Decodes 3-bit crew class codes into one-hot roles.
// Admits candidates up to QUOTA per role.
// Reports whether each transfer was admitted, rejected as over-quota, or illegal.
// Holds crew_done once every role is filled, until launch releases the crew.
module mars_crew_decoder #(
    parameter int QUOTA = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  launch,
    mars_crew_decoder_if.slave    code_if,
    output logic                  acc_pulse,
    output logic                  rej_pulse,
    output logic                  ill_pulse,
    output logic [4:0]            role_oh,
    output logic [5:0]            crew_count,
    output logic                  crew_done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

    localparam logic [2:0] QUOTA_C = 3'(QUOTA);

    state_t          state_q, state_d;
    logic [4:0][2:0] cnt_q, cnt_d;
    logic [5:0]      crew_count_q, crew_count_d;
    logic [4:0]      role_oh_q, role_oh_d;
    logic            acc_q, acc_d;
    logic            rej_q, rej_d;
    logic            ill_q, ill_d;

    logic            legal;
    logic [2:0]      role_idx;
    logic [4:0]      role_dec;
    logic            transfer;
    logic            all_full;

    // Map a class code onto its role index and one-hot role; unused codes are illegal.
    always_comb begin
        legal    = 1'b1;
        role_idx = 3'd0;
        role_dec = 5'b00000;
        case (code_if.code)
            3'b000: begin role_idx = 3'd0; role_dec = 5'b00001; end
            3'b001: begin role_idx = 3'd1; role_dec = 5'b00010; end
            3'b010: begin role_idx = 3'd2; role_dec = 5'b00100; end
            3'b100: begin role_idx = 3'd3; role_dec = 5'b01000; end
            3'b110: begin role_idx = 3'd4; role_dec = 5'b10000; end
            default: legal = 1'b0;
        endcase
    end

    // Ready depends on the state alone, so the upstream stage never sees a combinational path back from its own valid.
    assign code_if.code_ready = (state_q == COLLECT);
    assign transfer           = code_if.code_valid && (state_q == COLLECT);

    // Next-state logic: crew bookkeeping, per-transfer result pulses and FSM transitions.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        crew_count_d = crew_count_q;
        role_oh_d    = role_oh_q;
        acc_d        = 1'b0;
        rej_d        = 1'b0;
        ill_d        = 1'b0;
        all_full     = 1'b1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = COLLECT;
                    cnt_d        = '0;
                    crew_count_d = 6'd0;
                end
            end
            COLLECT: begin
                if (transfer) begin
                    if (!legal) begin
                        ill_d = 1'b1;
                    end else if (cnt_q[role_idx] < QUOTA_C) begin
                        cnt_d[role_idx] = cnt_q[role_idx] + 3'd1;
                        crew_count_d    = crew_count_q + 6'd1;
                        role_oh_d       = role_dec;
                        acc_d           = 1'b1;
                    end else begin
                        role_oh_d = role_dec;
                        rej_d     = 1'b1;
                    end
                end
                for (int i = 0; i < 5; i++) begin
                    if (cnt_d[i] != QUOTA_C) begin
                        all_full = 1'b0;
                    end
                end
                if (all_full) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (launch) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset discards any partial crew immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            crew_count_q <= 6'd0;
            role_oh_q    <= 5'b00000;
            acc_q        <= 1'b0;
            rej_q        <= 1'b0;
            ill_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            crew_count_q <= crew_count_d;
            role_oh_q    <= role_oh_d;
            acc_q        <= acc_d;
            rej_q        <= rej_d;
            ill_q        <= ill_d;
        end
    end

    assign acc_pulse  = acc_q;
    assign rej_pulse  = rej_q;
    assign ill_pulse  = ill_q;
    assign role_oh    = role_oh_q;
    assign crew_count = crew_count_q;
    assign crew_done  = (state_q == FULL);

endmodule

// File: tb/tb_mars_crew_decoder.sv
// Directed testbench for mars_crew_decoder with QUOTA=2.
// Inputs change on the falling edge, and outputs are sampled on the falling edge after each rising edge.
module tb_mars_crew_decoder;

    logic       clk;
    logic       reset;
    logic       start;
    logic       launch;
    logic       acc_pulse;
    logic       rej_pulse;
    logic       ill_pulse;
    logic [4:0] role_oh;
    logic [5:0] crew_count;
    logic       crew_done;

    int checks;
    int failures;

    logic [2:0] codes [5];
    logic [4:0] roles [5];

    mars_crew_decoder_if cif ();

    mars_crew_decoder #(.QUOTA(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .launch     (launch),
        .code_if    (cif),
        .acc_pulse  (acc_pulse),
        .rej_pulse  (rej_pulse),
        .ill_pulse  (ill_pulse),
        .role_oh    (role_oh),
        .crew_count (crew_count),
        .crew_done  (crew_done)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle of inputs and return on the following falling edge.
    task automatic applyStimulus(input logic st, input logic la, input logic vld, input logic [2:0] cd);
        start          = st;
        launch         = la;
        cif.code_valid = vld;
        cif.code       = cd;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Compare all outputs as {ready,acc,rej,ill,role,count,done} against hand-computed values.
    task automatic checkOutput(input string tag, input logic rdy, input logic acc, input logic rej,
                               input logic ill, input logic [4:0] role, input logic [5:0] cnt,
                               input logic done);
        logic [15:0] obs;
        logic [15:0] exp_v;
        obs   = {cif.code_ready, acc_pulse, rej_pulse, ill_pulse, role_oh, crew_count, crew_done};
        exp_v = {rdy, acc, rej, ill, role, cnt, done};
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    // Admit two of every role so the crew reaches FULL.
    task automatic fillCrew();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, codes[i / 2]);
        end
    endtask

    // Linear directed sequence.
    initial begin
        checks   = 0;
        failures = 0;
        codes    = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
        roles    = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};

        start          = 1'b0;
        launch         = 1'b0;
        cif.code_valid = 1'b0;
        cif.code       = 3'b000;
        reset          = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 6'd0, 1'b0);
        reset = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
        checkOutput("start_collect", 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 6'd0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, codes[i / 2]);
            checkOutput($sformatf("admit_%0d", i), (i != 9), 1'b1, 1'b0, 1'b0,
                        roles[i / 2], 6'(i + 1), (i == 9));
        end

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 3'b001);
            checkOutput($sformatf("full_hold_%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 5'b10000, 6'd10, 1'b1);
        end

        applyStimulus(1'b0, 1'b1, 1'b0, 3'b000);
        checkOutput("launch_idle", 1'b0, 1'b0, 1'b0, 1'b0, 5'b10000, 6'd10, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b1, 3'b000);
        checkOutput("idle_valid_ignored", 1'b0, 1'b0, 1'b0, 1'b0, 5'b10000, 6'd10, 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
        checkOutput("restart_clear", 1'b1, 1'b0, 1'b0, 1'b0, 5'b10000, 6'd0, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b1, 3'b000);
        checkOutput("role0_first", 1'b1, 1'b1, 1'b0, 1'b0, 5'b00001, 6'd1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 3'b000);
        checkOutput("role0_second", 1'b1, 1'b1, 1'b0, 1'b0, 5'b00001, 6'd2, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 3'b000);
        checkOutput("role0_reject", 1'b1, 1'b0, 1'b1, 1'b0, 5'b00001, 6'd2, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b1, 3'b010);
        checkOutput("role2_admit", 1'b1, 1'b1, 1'b0, 1'b0, 5'b00100, 6'd3, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 3'b011);
        checkOutput("illegal_011", 1'b1, 1'b0, 1'b0, 1'b1, 5'b00100, 6'd3, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 3'b101);
        checkOutput("illegal_101", 1'b1, 1'b0, 1'b0, 1'b1, 5'b00100, 6'd3, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 3'b111);
        checkOutput("illegal_111", 1'b1, 1'b0, 1'b0, 1'b1, 5'b00100, 6'd3, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000);
        checkOutput("no_transfer_quiet", 1'b1, 1'b0, 1'b0, 1'b0, 5'b00100, 6'd3, 1'b0);

        cif.code_valid = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_midcycle", 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 6'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_released", 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 6'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
        checkOutput("fresh_start", 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 6'd0, 1'b0);

        fillCrew();
        checkOutput("refill_done", 1'b0, 1'b1, 1'b0, 1'b0, 5'b10000, 6'd10, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b000);
        checkOutput("start_launch_together", 1'b0, 1'b0, 1'b0, 1'b0, 5'b10000, 6'd10, 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
        checkOutput("third_start", 1'b1, 1'b0, 1'b0, 1'b0, 5'b10000, 6'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, codes[i]);
        end
        checkOutput("four_admits", 1'b1, 1'b1, 1'b0, 1'b0, 5'b01000, 6'd4, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
        checkOutput("start_in_collect_ignored", 1'b1, 1'b0, 1'b0, 1'b0, 5'b01000, 6'd4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mars_crew_decoder.md
Name: mars_crew_decoder

Overview:
- Consumes the 3-bit crew class codes (C2,C1,C0) produced by the trait classifier and decodes each one into a one-hot role.
- Admits candidates into a mission crew under a per-role quota, and flags illegal codes and over-quota rejects.
- Asserts crew_done when every role quota is filled, holds until launch, then returns to idle.
- Sits downstream of the classifier, between candidate intake and mission launch logic.

Parameters:
- QUOTA, 2, candidates required per role; legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; opens a new crew collection.
- launch  input  1  single-cycle pulse; releases a completed crew.
- code_valid  input  1  code carries a candidate this cycle.
- code  input  3  class code {C2,C1,C0}.
- code_ready  output  1  block accepts a code this cycle.
- acc_pulse  output  1  one-cycle pulse: previous transfer admitted.
- rej_pulse  output  1  one-cycle pulse: previous transfer legal but its role was already full.
- ill_pulse  output  1  one-cycle pulse: previous transfer carried an illegal code.
- role_oh  output  5  one-hot role of the last legal transfer.
- crew_count  output  6  total admitted candidates in the current crew.
- crew_done  output  1  all role quotas met.

Behaviour:
- Reset (async, any state): state=IDLE; all role counters=0; crew_count=0; role_oh=0; acc/rej/ill pulses=0; crew_done=0; code_ready=0.
- Code decode:
  - 000 -> role0 (00001)
  - 001 -> role1 (00010)
  - 010 -> role2 (00100)
  - 100 -> role3 (01000)
  - 110 -> role4 (10000)
  - 011, 101, 111 are illegal.
- FSM states: IDLE, COLLECT, FULL.
  - IDLE: start -> COLLECT. Clear all counters and crew_count on that edge. launch is ignored.
  - COLLECT: code_ready=1 (Moore, decoded from state only).
  - FULL: code_ready=0, crew_done=1. launch -> IDLE on that edge; crew_done drops in the same cycle. Counters hold until the next start. start is ignored.
- Transfer: occurs on a rising edge where code_valid and code_ready are both 1. Only one transfer per cycle.
- Result of a transfer, registered, visible 1 cycle after the transfer edge:
  - Illegal code: ill_pulse=1; role_oh and counters unchanged.
  - Legal code, role counter < QUOTA: role counter +1, crew_count +1, role_oh=decoded role, acc_pulse=1.
  - Legal code, role counter == QUOTA: role_oh=decoded role, rej_pulse=1, counters unchanged.
- Exactly one of acc/rej/ill pulses per transfer; all three are 0 in cycles without a transfer.
- Completion: on the edge where the admitting transfer makes all five counters equal QUOTA, state goes to FULL. code_ready is 0 from the next cycle, and crew_done rises together with that final acc_pulse.
- Role counters are 3 bits and never exceed QUOTA. crew_count is 6 bits; its maximum is 5*QUOTA = 35, so it never wraps.
- code_valid while in IDLE or FULL: no transfer and no pulses. The upstream stage must hold its code.
- start in COLLECT is ignored; the partial crew is preserved.
- start and launch asserted together in FULL: launch wins; next state is IDLE.
- Reset asserted mid-COLLECT discards the partial crew immediately, without waiting for a clock edge.

Test Plan:
- Reset, then start, then codes 000,001,010,100,110 each twice with valid held high (QUOTA=2) -> code_ready=1 throughout, 10 acc_pulses, crew_count 1..10, crew_done=1 with the 10th acc_pulse, code_ready=0 the next cycle.
- In COLLECT, code=011, then 101, then 111 -> three ill_pulses, role_oh stays at its previous value, crew_count unchanged.
- With role0 at 2, send code 000 -> rej_pulse=1, role_oh=00001, crew_count unchanged, state stays COLLECT.
- In FULL, hold code_valid=1 with code=001 for 4 cycles -> no pulses, crew_count stays 10. Pulse launch -> crew_done=0 and state IDLE next cycle. Pulse start -> crew_count=0.
- After 3 admits, assert reset between clock edges -> all outputs 0 before the next edge. Release reset, then start -> fresh crew_count=0.
- In FULL, pulse start and launch together -> IDLE, crew_done=0, code_ready=0. start alone in COLLECT with crew_count=4 -> crew_count stays 4.
